// File: rtl/keypad_pkg.sv
// Shared types, column strobe patterns and row decoding helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {NONE, HIT, MULTI} scan_res_e;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_e;

  localparam logic [3:0] COL_PAT_0 = 4'b1110;
  localparam logic [3:0] COL_PAT_1 = 4'b1101;
  localparam logic [3:0] COL_PAT_2 = 4'b1011;
  localparam logic [3:0] COL_PAT_3 = 4'b0111;

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    unique case (idx)
      2'd0:    pat = COL_PAT_0;
      2'd1:    pat = COL_PAT_1;
      2'd2:    pat = COL_PAT_2;
      default: pat = COL_PAT_3;
    endcase
    return pat;
  endfunction

  // Index of the lowest active (low) row; only meaningful when exactly one row is low.
  function automatic logic [1:0] row_to_idx(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] row);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~row[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Key event FIFO with valid/ready head; drops pushes when full (unless popped the same
// cycle) and flags each drop with a one-cycle overflow pulse.
module key_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  key_code_t data_i,
  input  logic      ready_i,
  output logic      valid_o,
  output key_code_t data_o,
  output logic      overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  key_code_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = ready_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && full && !do_pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count_q qualifies every read, so stale
  // entries are never visible and the array can map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner, per-scan debouncer and press-event scheduler.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       overflow
);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_idx_q;
  logic [3:0]        col_q;
  logic              scan_hit_q, scan_multi_q;
  key_code_t         scan_code_q;

  logic      sample, scan_done, same_hit;
  logic [2:0] slot_low;
  logic      slot_hit, slot_multi, acc_hit, acc_multi;
  key_code_t acc_code;
  scan_res_e scan_res;

  assign sample    = (slot_q == SLOT_LAST);
  assign scan_done = sample && (col_idx_q == 2'd3);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slot_low   = 3'd0;
    slot_hit   = 1'b0;
    slot_multi = 1'b0;
    acc_hit    = scan_hit_q;
    acc_multi  = scan_multi_q;
    acc_code   = scan_code_q;
    scan_res   = NONE;
    if (sample) begin
      slot_low   = low_count(row);
      slot_hit   = (slot_low == 3'd1);
      slot_multi = (slot_low > 3'd1);
      acc_hit    = scan_hit_q | slot_hit;
      acc_multi  = scan_multi_q | slot_multi | (slot_hit & scan_hit_q);
      if (slot_hit) acc_code = {col_idx_q, row_to_idx(row)};
    end
    if (acc_multi)    scan_res = MULTI;
    else if (acc_hit) scan_res = HIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= '0;
      col_idx_q    <= 2'd0;
      col_q        <= COL_PAT_0;
      scan_hit_q   <= 1'b0;
      scan_multi_q <= 1'b0;
      scan_code_q  <= '0;
    end else if (sample) begin
      slot_q    <= '0;
      col_idx_q <= col_idx_q + 1'b1;
      col_q     <= col_pattern(col_idx_q + 1'b1);
      // The accumulator restarts with every new scan; the finished result feeds the FSM.
      scan_hit_q   <= scan_done ? 1'b0 : acc_hit;
      scan_multi_q <= scan_done ? 1'b0 : acc_multi;
      scan_code_q  <= scan_done ? '0 : acc_code;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  kp_state_e        state_q;
  key_code_t        cand_q, push_code_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_q;

  assign same_hit = (scan_res == HIT) && (acc_code == cand_q);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt_q, rep_last;
  logic             rep_started_q;
  assign rep_last = rep_started_q ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q     <= '0;
      rep_started_q <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (scan_done) begin
        unique case (state_q)
          IDLE: begin
            if (scan_res == HIT) begin
              cand_q <= acc_code;
              cnt_q  <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= HELD;
                push_q      <= 1'b1;
                push_code_q <= acc_code;
              end else begin
                state_q <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (same_hit) begin
              if (cnt_q == DB_LAST) begin
                state_q     <= HELD;
                push_q      <= 1'b1;
                push_code_q <= cand_q;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else if (scan_res == HIT) begin
              cand_q <= acc_code;
              cnt_q  <= CNT_ONE;
            end else begin
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (same_hit) begin
`ifdef KEYPAD_REPEAT_EN
              if (rep_cnt_q == rep_last) begin
                push_q        <= 1'b1;
                push_code_q   <= cand_q;
                rep_cnt_q     <= '0;
                rep_started_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
              end
`endif
            end else begin
              if (DEBOUNCE_SCANS == 1) state_q <= IDLE;
              else                     state_q <= REL_DB;
              cnt_q <= CNT_ONE;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_q     <= '0;
              rep_started_q <= 1'b0;
`endif
            end
          end
          REL_DB: begin
            if (same_hit) begin
              state_q <= HELD;
            end else if (scan_res == HIT) begin
              state_q <= PRESS_DB;
              cand_q  <= acc_code;
              cnt_q   <= CNT_ONE;
            end else if (cnt_q == DB_LAST) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign col = col_q;

  key_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_q),
    .data_i    (push_code_q),
    .ready_i   (key_ready),
    .valid_o   (key_valid),
    .data_o    (key_code),
    .overflow_o(overflow)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized self-checking bench for keypad_scan_ctrl against a scan-history reference model.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_ready, overflow;
  logic [15:0] keys;

  keypad_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_valid(key_valid),
    .key_code(key_code), .key_ready(key_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key at (c,r) pulls row r low while column c is strobed.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row[r] = 1'b0;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-scan results from the pressed-key set, history of the last DEB scans.
  int exp_q[$];
  int hist[$];
  int held = -1;
  int exp_ovf = 0;

  function automatic int scan_of(input logic [15:0] m);
    if (m == 16'h0) return -1;
    if ($countones(m) > 1) return -2;
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_scan(input logic [15:0] m);
    int r = scan_of(m);
    bit all_same = 1'b1;
    bit all_off = 1'b1;
    hist.push_back(r);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      foreach (hist[i]) begin
        if (hist[i] != r) all_same = 1'b0;
        if (hist[i] >= 0) all_off = 1'b0;
      end
      if (r >= 0 && all_same && held != r) begin
        held = r;
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back(r);
      end else if (all_off) begin
        held = -1;
      end
    end
  endtask

  // Consumer and monitor share one process so key_ready is settled before it is observed.
  int rdy_mode = 1;
  int n_pops = 0, ovf_cnt = 0, kv_cycles = 0, zero_viol = 0, hold_viol = 0;
  int slot_pos = 0, rise_pos = -1;
  logic [3:0] rise_col, prev_col, prev_code;
  logic prev_kv = 1'b0, prev_hold = 1'b0;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       key_ready = 1'b0;
      1:       key_ready = 1'b1;
      default: key_ready = ($urandom_range(3) != 0);
    endcase
    if (reset) begin
      slot_pos  = 0;
      prev_kv   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (col != prev_col) slot_pos = 0;
      else slot_pos++;
      if (overflow) ovf_cnt++;
      if (key_valid) kv_cycles++;
      if (!key_valid && key_code != 4'h0) zero_viol++;
      if (prev_hold && key_valid && key_code != prev_code) hold_viol++;
      if (key_valid && !prev_kv) begin
        rise_pos = slot_pos;
        rise_col = col;
      end
      if (key_valid && key_ready) begin
        n_pops++;
        check("event_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("event_code", key_code, exp_q.pop_front());
      end
      prev_kv   = key_valid;
      prev_hold = key_valid && !key_ready;
      prev_code = key_code;
    end
    prev_col = col;
  end

  task automatic wait_scan_start();
    logic [3:0] last;
    bit found = 1'b0;
    last = col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && last == 4'b0111) found = 1'b1;
      last = col;
    end
    check("scan_sync", found, 1'b1);
  endtask

  task automatic run_scans(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      wait_scan_start();
      keys = m;
      model_scan(m);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int p0, k0, o0, e0, kv_seen, last_key, kind, len, k1, k2;
  logic [15:0] m;

  initial begin
    reset = 1'b1;
    keys  = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: column rotation and idle outputs
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_overflow", overflow, 1'b0);
    kv_seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (i < 32) check("col_rotation", col, 4'b1111 & ~(4'b0001 << ((i / SCAN_DIV) % 4)));
      if (key_valid) kv_seen++;
      @(negedge clk);
    end
    check("idle_no_valid", kv_seen, 0);

    // 2: single press of key C
    rdy_mode = 1;
    p0 = n_pops; k0 = kv_cycles;
    run_scans(16'h0, 1);
    run_scans(16'h1 << 12, 3);
    run_scans(16'h0, 3);
    check("c_pops", n_pops - p0, 1);
    check("c_valid_cycles", kv_cycles - k0, 1);
    check("c_rise_col", rise_col, 4'b1110);
    check("c_rise_pos", rise_pos, 1);
    check("c_queue_empty", exp_q.size(), 0);

    // 3: one-scan bounce of key 5
    p0 = n_pops; k0 = kv_cycles;
    run_scans(16'h1 << 5, 1);
    run_scans(16'h0, 3);
    check("bounce_pops", n_pops - p0, 0);
    check("bounce_valid", kv_cycles - k0, 0);

    // 4: five presses with consumer stalled, fifth dropped
    rdy_mode = 0;
    p0 = n_pops; o0 = ovf_cnt; e0 = exp_ovf;
    for (int k = 1; k <= 5; k++) begin
      run_scans(16'h1 << k, 3);
      run_scans(16'h0, 2);
    end
    check("ovf_pulses", ovf_cnt - o0, exp_ovf - e0);
    check("ovf_once", ovf_cnt - o0, 1);
    check("full_valid", key_valid, 1'b1);
    check("full_head", key_code, exp_q[0]);
    rdy_mode = 1;
    run_scans(16'h0, 2);
    check("drain_pops", n_pops - p0, 4);
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", key_valid, 1'b0);

    // 5: two rows in one column is MULTI, then a clean press of key 0
    p0 = n_pops;
    run_scans(16'h0003, 4);
    check("multi_pops", n_pops - p0, 0);
    run_scans(16'h0001, 3);
    run_scans(16'h0, 3);
    check("key0_pops", n_pops - p0, 1);

    // 6: reset during a pending press with a queued event
    rdy_mode = 0;
    run_scans(16'h1 << 9, 3);
    run_scans(16'h0, 2);
    run_scans(16'h1 << 6, 1);
    repeat (5) @(negedge clk);
    check("pre_reset_valid", key_valid, exp_q.size() != 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_valid", key_valid, 1'b0);
    check("post_reset_col", col, 4'b1110);
    check("post_reset_code", key_code, 4'h0);
    exp_q.delete();
    hist.delete();
    held = -1;
    model_scan(keys);
    rdy_mode = 1;
    p0 = n_pops; k0 = kv_cycles;
    run_scans(16'h0, 4);
    check("post_reset_pops", n_pops - p0, 0);
    check("post_reset_kv", kv_cycles - k0, 0);

    // Randomized key activity with a randomly stalling consumer
    rdy_mode = 2;
    last_key = -1;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(9);
      len  = $urandom_range(4, 1);
      if (kind < 3) begin
        m = 16'h0;
        last_key = -1;
      end else if (kind < 9) begin
        k1 = $urandom_range(15);
        if (last_key >= 0 && k1 != last_key) run_scans(16'h0, 1);
        m = 16'h1 << k1;
        last_key = k1;
      end else begin
        k1 = $urandom_range(15);
        k2 = (k1 + $urandom_range(15, 1)) % 16;
        m = (16'h1 << k1) | (16'h1 << k2);
        last_key = -1;
      end
      run_scans(m, len);
    end
    run_scans(16'h0, 3);
    rdy_mode = 1;
    run_scans(16'h0, 2);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_valid_low", key_valid, 1'b0);
    check("total_overflows", ovf_cnt, exp_ovf);
    check("code_zero_when_empty", zero_viol, 0);
    check("code_stable_when_stalled", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller and event scheduler for the 4x4 matrix keypad that feeds maze movement commands. It drives the column strobes, samples the rows, debounces per full scan, and turns stable presses into key-press events. Events are buffered in a small FIFO so the game FSM can consume them with a valid/ready handshake without losing presses.

Parameters:
SCAN_DIV, 1000, clock cycles each column strobe is held (>=2)
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or release (>=1)
FIFO_DEPTH, 4, event FIFO entries (power of 2)
REPEAT_DELAY, 50, full scans held before first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 10, full scans between auto-repeats (used only with KEYPAD_REPEAT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
row  in  4  keypad rows, active-low (1111 = no key)
col  out  4  column strobe, one-hot active-low
key_valid  out  1  FIFO head holds an event
key_code  out  4  event code = col_index*4 + row_index
key_ready  in  1  consumer accepts the head event
overflow  out  1  one-cycle pulse when an event is dropped (FIFO full)

Behaviour:
- Reset (sync, active-high): col=1110, slot counter=0, col_index=0, FSM=IDLE, FIFO empty, key_valid=0, key_code=0, overflow=0. Reset asserted mid-scan or mid-debounce discards all partial state and queued events.
- Column sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110; each held exactly SCAN_DIV cycles. Row is sampled on the last cycle of each slot only (settling).
- Per-scan result (evaluated after col 0111 slot): exactly one low row bit across all four slots -> HIT with code; no low bits -> NONE; more than one low bit in a slot or hits in >1 slot -> MULTI (treated as NONE for release counting, never produces an event).
- FSM (updates once per completed scan):
  IDLE: HIT code X -> PRESS_DB (cand=X, cnt=1; if DEBOUNCE_SCANS=1 go straight to HELD with event).
  PRESS_DB: HIT X -> cnt++; cnt reaching DEBOUNCE_SCANS -> push X, go HELD. HIT Y!=X -> cand=Y, cnt=1. NONE/MULTI -> IDLE.
  HELD: HIT X -> stay. Anything else -> REL_DB, cnt=1.
  REL_DB: NONE/MULTI -> cnt++; at DEBOUNCE_SCANS -> IDLE. HIT X -> HELD (no new event). HIT Y!=X -> PRESS_DB cand=Y.
- Exactly one event per debounced press; release generates no event.
- Push occurs on the cycle after the final row sample of the qualifying scan; key_valid rises on the next cycle if FIFO was empty.
- FIFO: pop when key_valid && key_ready; key_code is head entry, held stable while key_valid && !key_ready. Push while full and no pop -> event dropped, overflow=1 for one cycle. Push and pop same cycle while full -> both accepted. Pointers wrap modulo FIFO_DEPTH; ordering strictly FIFO.
- key_code = 0 when FIFO empty.

Optional Feature:
KEYPAD_REPEAT_EN: when defined, in HELD a scan counter pushes key X again after REPEAT_DELAY full scans, then every REPEAT_RATE scans while still held; counter clears on leaving HELD. Repeats obey the same FIFO/overflow rules. When undefined, HELD never pushes and REPEAT_* are unused.

Decomposition:
- Package keypad_pkg: key code typedef (4 bits), scan-result enum (NONE/HIT/MULTI), FSM state enum (IDLE/PRESS_DB/HELD/REL_DB), column pattern constants, row-to-index function.
- One sub-module: key_evt_fifo (parameterised depth, push/pop, full/empty, valid/ready head). Scan, debounce and FSM stay in top level.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4):
1. Reset then idle rows=1111 -> col=1110 first cycle after reset, rotates every 4 cycles, key_valid=0 for 200 cycles.
2. Drive row=1110 only while col=0111 for 3 scans, key_ready=1 -> exactly one event key_code=4'hC, key_valid high one cycle.
3. Bounce: key 5 (col 1101, row 1101) for 1 scan then release -> no event.
4. key_ready=0, five debounced press/release of codes 1,2,3,4,5 -> head shows 1,2,3,4 in order after popping, code 5 dropped, overflow pulses once.
5. row=1100 during col 1110 slot for 4 scans -> MULTI, no event; same press with single row bit -> event code 0.
6. Assert reset for 1 cycle while key_valid=1 and FSM in PRESS_DB -> next cycle key_valid=0, col=1110, no event emitted from the interrupted press.
